mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported data memory between speculative loads from the load/store unit and committed stores.
//  Committed stores enter a write queue and drain when the port is free.
//  Loads return with fixed latency MEM_LAT, tagged with their ROB slot.
//  Sits between the load/store unit, the commit stage and the data memory.
// PARAMETERS
//  DATA_W      16  data width
//  ADDR_W      16  address width
//  ROB_W       6   ROB tag width
//  WQ_DEPTH    4   write-queue entries (power of 2, >=2)
//  MEM_LAT     3   memory read latency in cycles (>=1)
//  STARVE_MAX  4   consecutive load grants with a non-empty WQ before a store drain is forced
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high
//  flush      in   1       squash in-flight load responses (mispredict)
//  ld_valid   in   1       load request
//  ld_addr    in   ADDR_W  load address
//  ld_rob     in   ROB_W   load ROB tag
//  ld_ready   out  1       load accepted this cycle when ld_valid&&ld_ready
//  st_valid   in   1       committed store
//  st_addr    in   ADDR_W  store address
//  st_data    in   DATA_W  store data
//  st_ready   out  1       = !wq_full
//  mem_ren    out  1       memory read strobe
//  mem_wen    out  1       memory write strobe (never together with mem_ren)
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  write data
//  mem_rdata  in   DATA_W  read data, valid MEM_LAT cycles after mem_ren
//  resp_valid out  1       load result valid
//  resp_data  out  DATA_W  load result
//  resp_rob   out  ROB_W   ROB tag of result
// BEHAVIOUR
//  - Reset: WQ empty, pipeline valids 0, starve counter 0. ld_ready=1, st_ready=1, mem_ren=mem_wen=resp_valid=0.
//  - One memory op per cycle. grant_st = wq_nonempty && (!ld_valid || wq_full || starve==STARVE_MAX); otherwise a valid load is granted.
//  - ld_ready = !grant_st && !conflict. conflict = ld_addr matches a valid WQ entry or an incoming accepted store. With MEM_ARB_FWD_EN, conflict is always 0.
//  - Accepted load: mem_ren=1, mem_addr=ld_addr, and {1,rob,fwd,fwd_data} enters a MEM_LAT-deep shift pipe.
//  - At the pipe end: resp_valid=1; resp_data = fwd ? fwd_data : mem_rdata (combinational). Latency is exactly MEM_LAT cycles, in order.
//  - Store drain: pops the WQ head; mem_wen=1 with head addr/data. Only registered entries drain, so a store reaches memory at least 1 cycle after acceptance. A write in cycle t is visible to a read in cycle t+1.
//  - Starve counter: increments on a load grant while WQ is non-empty. It clears on a store grant or when WQ is empty and saturates at STARVE_MAX.
//  - WQ push and pop may occur in the same cycle; count is unchanged. Pointers wrap modulo WQ_DEPTH.
//  - WQ full: st_ready=0 and a drain is forced that cycle, so st_ready rises the next cycle.
//  - flush: clears all pipe valids, so in-flight responses are dropped and resp_valid=0 next cycle. ld_ready=0 in the flush cycle.
//    The WQ and starve counter are NOT flushed, because stores are committed.
//  - reset mid-operation: WQ contents are discarded; the same state as reset applies.
// CONFIGURATION
//  MEM_ARB_FWD_EN defined: a conflicting load is accepted, not stalled.
//    Forwarded data comes from the youngest match: the incoming store first, then the youngest WQ entry.
//    The load still issues mem_ren, but resp_data uses the forwarded value.
//  Undefined: a conflicting load is stalled (ld_ready=0) until the matching entries drain. fwd bit tied to 0.
// STRUCTURE
//  Package mem_arb_pkg holds DATA_W/ADDR_W/ROB_W localparams and the load pipe entry struct {valid,rob,fwd,data}.
//  Sub-module mem_arb_wq: the write-queue FIFO plus an address CAM search port returning {hit, youngest_data}.
// TESTING
//  1 Reset, then a load at 0x0010 with rob 5 and mem holding 0xBEEF -> resp 0xBEEF, rob 5 exactly 3 cycles later.
//  2 Store 0x0020=0x1234, then idle -> mem_wen with addr 0x0020 one cycle after acceptance; WQ empty afterwards.
//  3 Continuous loads plus 1 queued store -> the store drains at the 5th cycle (STARVE_MAX=4); ld_ready=0 that cycle.
//  4 4 stores with no drain because loads win, then a 5th store -> st_ready=0 and a forced drain; accepted the next cycle.
//  5 Store 0x0030=0xAAAA queued, then a load at 0x0030 -> FWD_EN: resp 0xAAAA after 3 cycles. No FWD_EN: ld_ready=0 until drained, then reads 0xAAAA.
//  6 Two loads in flight, then flush -> no resp_valid; the queued store still drains; a new load after the flush returns normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared widths and the load-pipe entry type for the memory
//                port arbiter.
//  Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int ROB_W  = 6;

    // One in-flight load: forwarded loads carry their data with them so the
    // response mux never has to look back into the write queue.
    typedef struct packed {
        logic              valid;
        logic [ROB_W-1:0]  rob;
        logic              fwd;
        logic [DATA_W-1:0] data;
    } ld_pipe_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_wq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_wq
//  Description : Committed-store write queue (FIFO) with an address search
//                port returning the youngest matching entry.
//  Revision    : 1.0
// ============================================================================
module mem_arb_wq
    import mem_arb_pkg::*;
#(
    parameter int WQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] srch_addr,
    output logic              srch_hit,
    output logic [DATA_W-1:0] srch_data
);

    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr_q [WQ_DEPTH];
    logic [DATA_W-1:0] r_data_q [WQ_DEPTH];

    logic [PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_W-1:0] r_count_q,  w_count_d;
    logic [PTR_W-1:0] w_idx;

    assign full      = (r_count_q == CNT_W'(WQ_DEPTH));
    assign empty     = (r_count_q == '0);
    assign head_addr = r_addr_q[r_rd_ptr_q];
    assign head_data = r_data_q[r_rd_ptr_q];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (push) begin
            w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   w_count_d = r_count_q + CNT_W'(1);
            2'b01:   w_count_d = r_count_q - CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    // Walk oldest to youngest so the last hit seen is the youngest store.
    always_comb begin
        srch_hit  = 1'b0;
        srch_data = '0;
        w_idx     = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            w_idx = r_rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < r_count_q) && (r_addr_q[w_idx] == srch_addr)) begin
                srch_hit  = 1'b1;
                srch_data = r_data_q[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_addr_q[r_wr_ptr_q] <= push_addr;
            r_data_q[r_wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares a single-ported data memory between speculative loads
//                and committed stores. Optional store-to-load forwarding is
//                enabled by defining MEM_ARB_FWD_EN.
//  Revision    : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WQ_DEPTH   = 4,
    parameter int MEM_LAT    = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ROB_W-1:0]  ld_rob,
    output logic              ld_ready,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [ROB_W-1:0]  resp_rob
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic              w_wq_full;
    logic              w_wq_empty;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_wq_hit;
    logic [DATA_W-1:0] w_wq_hit_data;

    logic              w_st_accept;
    logic              w_st_match;
    logic              w_conflict;
    logic              w_fwd;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_starved;
    logic              w_grant_st;
    logic              w_grant_ld;

    logic [SC_W-1:0]   r_starve_q, w_starve_d;
    ld_pipe_t          r_pipe_q [MEM_LAT];
    ld_pipe_t          w_pipe_d [MEM_LAT];

    mem_arb_wq #(
        .WQ_DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk       (clk),
        .reset     (reset),
        .push      (w_st_accept),
        .push_addr (st_addr),
        .push_data (st_data),
        .pop       (w_grant_st),
        .head_addr (w_head_addr),
        .head_data (w_head_data),
        .full      (w_wq_full),
        .empty     (w_wq_empty),
        .srch_addr (ld_addr),
        .srch_hit  (w_wq_hit),
        .srch_data (w_wq_hit_data)
    );

    assign st_ready    = !w_wq_full;
    assign w_st_accept = st_valid && !w_wq_full;
    assign w_st_match  = w_st_accept && (st_addr == ld_addr);
    assign w_starved   = (r_starve_q == SC_W'(STARVE_MAX));

`ifdef MEM_ARB_FWD_EN
    assign w_conflict = 1'b0;
    assign w_fwd      = w_st_match || w_wq_hit;
`else
    assign w_conflict = w_st_match || w_wq_hit;
    assign w_fwd      = 1'b0;
`endif
    // Incoming store is younger than anything already queued.
    assign w_fwd_data = w_st_match ? st_data : w_wq_hit_data;

    // A load stalled on a queued address cannot use the port, so the queue
    // drains instead; otherwise the load and its blocking store deadlock.
    assign w_grant_st = !w_wq_empty && (!ld_valid || w_wq_full || w_starved || w_conflict);
    assign ld_ready   = !w_grant_st && !w_conflict && !flush;
    assign w_grant_ld = ld_valid && ld_ready;

    assign mem_ren   = w_grant_ld;
    assign mem_wen   = w_grant_st;
    assign mem_addr  = w_grant_st ? w_head_addr : ld_addr;
    assign mem_wdata = w_head_data;

    always_comb begin
        w_starve_d = r_starve_q;
        if (w_wq_empty || w_grant_st) begin
            w_starve_d = '0;
        end else if (w_grant_ld && !w_starved) begin
            w_starve_d = r_starve_q + SC_W'(1);
        end
    end

    always_comb begin
        w_pipe_d[0] = '{valid: w_grant_ld, rob: ld_rob, fwd: w_fwd, data: w_fwd_data};
        for (int i = 1; i < MEM_LAT; i++) begin
            w_pipe_d[i] = r_pipe_q[i-1];
        end
        if (flush) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                w_pipe_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pipe_q[i] <= '0;
            end
        end else begin
            r_starve_q <= w_starve_d;
            r_pipe_q   <= w_pipe_d;
        end
    end

    assign resp_valid = r_pipe_q[MEM_LAT-1].valid;
    assign resp_rob   = r_pipe_q[MEM_LAT-1].rob;
    assign resp_data  = r_pipe_q[MEM_LAT-1].fwd ? r_pipe_q[MEM_LAT-1].data : mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter with a
//                fixed-latency memory model and a response scoreboard.
//  Revision    : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        ld_valid, ld_ready;
    logic [15:0] ld_addr;
    logic [5:0]  ld_rob;
    logic        st_valid, st_ready;
    logic [15:0] st_addr, st_data;
    logic        mem_ren, mem_wen;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [5:0]  resp_rob;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [5:0]  rob;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb [$];

    logic [15:0] mem [4096];
    logic [15:0] rd_pipe [MEM_LAT];

    always #5 clk = ~clk;

    mem_port_arbiter u_dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_rob     (ld_rob),
        .ld_ready   (ld_ready),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rob   (resp_rob)
    );

    function automatic logic [15:0] bg(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Data memory: writes land on the edge, reads return MEM_LAT cycles later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wen) mem[mem_addr[11:0]] <= mem_wdata;
        rd_pipe[0] <= mem_ren ? mem[mem_addr[11:0]] : 16'h0000;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [5:0] rob, input logic [15:0] data);
        exp_t e;
        e.rob  = rob;
        e.data = data;
        e.cyc  = cyc + MEM_LAT;
        sb.push_back(e);
    endtask

    task automatic drive_ld(input logic v, input logic [15:0] a, input logic [5:0] r);
        ld_valid = v;
        ld_addr  = a;
        ld_rob   = r;
    endtask

    task automatic drive_st(input logic v, input logic [15:0] a, input logic [15:0] d);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic wait_sb(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        check("sb_drained", sb.size(), 0);
    endtask

    // Response monitor: every response must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && resp_valid) begin
                n_tests++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL resp_unexpected: observed rob %0d data 0x%0h, expected no response", resp_rob, resp_data);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_rob",  resp_rob,  e.rob);
                    check("resp_data", resp_data, e.data);
                    check("resp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] sa;
        for (int i = 0; i < 4096; i++) mem[i] = bg(16'(i));
        mem[12'h010] = 16'hBEEF;
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = 16'h0000;

        reset = 1'b1;
        flush = 1'b0;
        drive_ld(1'b0, 16'h0, 6'd0);
        drive_st(1'b0, 16'h0, 16'h0);
        repeat (3) step();

        // Reset state
        sample();
        check("rst_ld_ready",   ld_ready,   1'b1);
        check("rst_st_ready",   st_ready,   1'b1);
        check("rst_mem_ren",    mem_ren,    1'b0);
        check("rst_mem_wen",    mem_wen,    1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        step();
        reset = 1'b0;

        // 1: single load, fixed latency
        drive_ld(1'b1, 16'h0010, 6'd5);
        sample();
        check("t1_ld_ready", ld_ready, 1'b1);
        check("t1_mem_ren",  mem_ren,  1'b1);
        check("t1_mem_addr", mem_addr, 16'h0010);
        push_exp(6'd5, 16'hBEEF);
        step();
        drive_ld(1'b0, 16'h0, 6'd0);
        wait_sb(10);

        // 2: lone store drains one cycle after acceptance, visible next cycle
        drive_st(1'b1, 16'h0020, 16'h1234);
        sample();
        check("t2_st_ready",   st_ready, 1'b1);
        check("t2_no_early_wr", mem_wen, 1'b0);
        step();
        drive_st(1'b0, 16'h0, 16'h0);
        sample();
        check("t2_mem_wen",   mem_wen,   1'b1);
        check("t2_mem_addr",  mem_addr,  16'h0020);
        check("t2_mem_wdata", mem_wdata, 16'h1234);
        step();
        drive_ld(1'b1, 16'h0020, 6'd6);
        sample();
        check("t2_wq_empty", mem_wen,  1'b0);
        check("t2_ld_ready", ld_ready, 1'b1);
        push_exp(6'd6, 16'h1234);
        step();
        drive_ld(1'b0, 16'h0, 6'd0);
        wait_sb(10);

        // 3: continuous loads starve a queued store until STARVE_MAX
        for (int k = 0; k < 7; k++) begin
            drive_ld(1'b1, 16'h0040 + 16'(k), 6'(10 + k));
            drive_st(k == 0, 16'h0200, 16'h7777);
            sample();
            check("t3_ld_ready", ld_ready, (k != 5));
            check("t3_mem_wen",  mem_wen,  (k == 5));
            if (k == 5) begin
                check("t3_mem_addr",  mem_addr,  16'h0200);
                check("t3_mem_wdata", mem_wdata, 16'h7777);
            end else begin
                push_exp(6'(10 + k), bg(16'h0040 + 16'(k)));
            end
            step();
        end
        drive_ld(1'b0, 16'h0, 6'd0);
        drive_st(1'b0, 16'h0, 16'h0);
        wait_sb(10);

        // 4: fill the queue behind loads, fifth store forces a drain
        for (int k = 0; k < 6; k++) begin
            sa = 16'((k > 4) ? 4 : k);
            drive_ld(1'b1, 16'h0050 + 16'(k), 6'(20 + k));
            drive_st(1'b1, 16'h0300 + sa, 16'h1000 + sa);
            sample();
            check("t4_st_ready", st_ready, (k != 4));
            check("t4_ld_ready", ld_ready, (k != 4));
            check("t4_mem_wen",  mem_wen,  (k == 4));
            if (k == 4) begin
                check("t4_forced_addr", mem_addr, 16'h0300);
            end else begin
                push_exp(6'(20 + k), bg(16'h0050 + 16'(k)));
            end
            step();
        end
        drive_ld(1'b0, 16'h0, 6'd0);
        drive_st(1'b0, 16'h0, 16'h0);
        for (int j = 1; j <= 4; j++) begin
            sample();
            check("t4_drain_wen",   mem_wen,   1'b1);
            check("t4_drain_addr",  mem_addr,  16'h0300 + 16'(j));
            check("t4_drain_wdata", mem_wdata, 16'h1000 + 16'(j));
            step();
        end
        sample();
        check("t4_drained", mem_wen, 1'b0);
        step();
        wait_sb(10);

        // 5: load hitting a queued store
        drive_st(1'b1, 16'h0030, 16'hAAAA);
        sample();
        check("t5_st_ready", st_ready, 1'b1);
        step();
        drive_st(1'b0, 16'h0, 16'h0);
        drive_ld(1'b1, 16'h0030, 6'd33);
        sample();
`ifdef MEM_ARB_FWD_EN
        check("t5_fwd_ld_ready", ld_ready, 1'b1);
        check("t5_fwd_no_wen",   mem_wen,  1'b0);
        push_exp(6'd33, 16'hAAAA);
        step();
        drive_ld(1'b0, 16'h0, 6'd0);
        sample();
        check("t5_fwd_drain_wen",  mem_wen,  1'b1);
        check("t5_fwd_drain_addr", mem_addr, 16'h0030);
        step();
`else
        check("t5_stall_ld_ready", ld_ready, 1'b0);
        check("t5_stall_wen",      mem_wen,  1'b1);
        check("t5_stall_addr",     mem_addr, 16'h0030);
        step();
        sample();
        check("t5_retry_ld_ready", ld_ready, 1'b1);
        check("t5_retry_ren",      mem_ren,  1'b1);
        push_exp(6'd33, 16'hAAAA);
        step();
        drive_ld(1'b0, 16'h0, 6'd0);
`endif
        wait_sb(10);

        // 6: flush drops in-flight loads but keeps the queued store
        drive_ld(1'b1, 16'h0060, 6'd40);
        drive_st(1'b1, 16'h0400, 16'h4444);
        sample();
        check("t6_ldA_ready", ld_ready, 1'b1);
        step();
        drive_st(1'b0, 16'h0, 16'h0);
        drive_ld(1'b1, 16'h0061, 6'd41);
        sample();
        check("t6_ldB_ready", ld_ready, 1'b1);
        step();
        drive_ld(1'b1, 16'h0062, 6'd44);
        flush = 1'b1;
        sample();
        check("t6_flush_ld_ready", ld_ready, 1'b0);
        check("t6_flush_ren",      mem_ren,  1'b0);
        step();
        flush = 1'b0;
        drive_ld(1'b0, 16'h0, 6'd0);
        sample();
        check("t6_drain_wen",  mem_wen,    1'b1);
        check("t6_drain_addr", mem_addr,   16'h0400);
        check("t6_no_respA",   resp_valid, 1'b0);
        step();
        drive_ld(1'b1, 16'h0400, 6'd42);
        sample();
        check("t6_no_respB",   resp_valid, 1'b0);
        check("t6_ldC_ready",  ld_ready,   1'b1);
        push_exp(6'd42, 16'h4444);
        step();
        drive_ld(1'b0, 16'h0, 6'd0);
        wait_sb(10);

        // 7: reset mid-operation discards the queued store
        drive_st(1'b1, 16'h0500, 16'h5555);
        sample();
        step();
        drive_st(1'b0, 16'h0, 16'h0);
        drive_ld(1'b1, 16'h0070, 6'd50);
        reset = 1'b1;
        step();
        drive_ld(1'b0, 16'h0, 6'd0);
        sample();
        check("t7_rst_wen",        mem_wen,    1'b0);
        check("t7_rst_st_ready",   st_ready,   1'b1);
        check("t7_rst_ld_ready",   ld_ready,   1'b1);
        check("t7_rst_resp_valid", resp_valid, 1'b0);
        step();
        reset = 1'b0;
        sample();
        check("t7_wq_discarded", mem_wen,    1'b0);
        check("t7_no_resp",      resp_valid, 1'b0);
        repeat (4) step();
        check("t7_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
